// File: rtl/sig_seq_checker.sv
// rtl/sig_seq_checker.sv - deglitching checker for an incrementing 3-bit generator code
// Synchronizes and filters sig_i, then checks that each accepted code change is the
// previous code plus one (mod 8). Counts transitions and errors for one run and
// reports pass, fail or timeout.
// Ports:
//   wb_clk_i     clock
//   wb_rst_i     asynchronous active-high reset
//   en_i         level enable: high starts and holds a check, low aborts or returns to idle
//   sig_i        generator code, asynchronous to wb_clk_i
//   target_i     number of transitions to check, latched when leaving idle
//   busy_o       run in progress (arming or running)
//   done_o       run finished, held until the next start
//   pass_o       run finished with no errors and no timeout
//   timeout_o    run ended because no transition arrived in time
//   err_cnt_o    mismatching transitions, saturating at 255
//   trans_cnt_o  accepted transitions in this run
//   last_code_o  last accepted code
module sig_seq_checker #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en_i,
  input  logic [2:0]       sig_i,
  input  logic [CNT_W-1:0] target_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [7:0]       err_cnt_o,
  output logic [CNT_W-1:0] trans_cnt_o,
  output logic [2:0]       last_code_o
);

  localparam int              SC_W      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_MAX    = SC_W'(STABLE_CYCLES - 1);
  localparam int              TMR_W     = 20;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]       s1, s2, cand, cur;
  logic [SC_W-1:0]  stab_cnt;
  logic             accept;
  logic             good_step;
  logic             hit_target;
  logic             tmr_expire;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] trans_nxt;
  logic [TMR_W-1:0] idle_tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic [7:0]       err_nxt;

  // Synchronizer and stability filter. cand follows s2; stab_cnt counts how long
  // it has matched, so a code is accepted only after STABLE_CYCLES steady samples.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1       <= '0;
      s2       <= '0;
      cand     <= '0;
      stab_cnt <= '0;
    end else begin
      s1 <= sig_i;
      s2 <= s1;
      if (s2 != cand) begin
        cand     <= s2;
        stab_cnt <= '0;
      end else if (stab_cnt != SC_MAX) begin
        stab_cnt <= stab_cnt + SC_W'(1);
      end
    end
  end

  assign accept     = (stab_cnt == SC_MAX) && (cand != cur);
  assign good_step  = (cand == 3'(cur + 3'd1));
  assign err_nxt    = (good_step || err_cnt_o == 8'hFF) ? err_cnt_o : err_cnt_o + 8'd1;
  assign trans_nxt  = trans_cnt_o + CNT_W'(1);
  assign hit_target = (trans_nxt == target_q);
  assign tmr_nxt    = idle_tmr + TMR_W'(1);
  assign tmr_expire = (tmr_nxt == TMR_LIMIT);
  assign busy_o     = (state == S_ARM) || (state == S_RUN);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Abort (en_i low) has priority in every active state; an accept masks a timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (en_i) state_nxt = S_ARM;
      S_ARM: begin
        if (!en_i)                 state_nxt = S_IDLE;
        else if (target_q == '0)   state_nxt = S_DONE;
        else                       state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en_i)                 state_nxt = S_IDLE;
        else if (accept) begin
          if (hit_target)          state_nxt = S_DONE;
        end else if (tmr_expire)   state_nxt = S_DONE;
      end
      S_DONE: if (!en_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cur         <= '0;
      target_q    <= '0;
      idle_tmr    <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_cnt_o   <= '0;
      trans_cnt_o <= '0;
      last_code_o <= '0;
    end else begin
      // Arming re-bases the reference on the current filtered code without counting it.
      if (accept || state == S_ARM) cur <= cand;
      case (state)
        S_IDLE: begin
          if (en_i) begin
            err_cnt_o   <= '0;
            trans_cnt_o <= '0;
            timeout_o   <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            idle_tmr    <= '0;
            target_q    <= target_i;
          end
        end
        S_ARM: begin
          if (en_i) begin
            last_code_o <= cand;
            if (target_q == '0) begin
              done_o <= 1'b1;
              pass_o <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (en_i) begin
            if (accept) begin
              trans_cnt_o <= trans_nxt;
              err_cnt_o   <= err_nxt;
              last_code_o <= cand;
              idle_tmr    <= '0;
              if (hit_target) begin
                done_o <= 1'b1;
                pass_o <= (err_nxt == 8'd0);
              end
            end else begin
              idle_tmr <= tmr_nxt;
              if (tmr_expire) begin
                done_o    <= 1'b1;
                timeout_o <= 1'b1;
                pass_o    <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_seq_checker.sv
// tb/tb_sig_seq_checker.sv - randomized and directed bench for sig_seq_checker
module tb_sig_seq_checker;

  localparam int STB = 4;
  localparam int TMO = 1000;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic [2:0]  sig_i;
  logic [15:0] target_i;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [7:0]  err_cnt_o;
  logic [15:0] trans_cnt_o;
  logic [2:0]  last_code_o;

  int checks;
  int errors;

  sig_seq_checker #(
    .STABLE_CYCLES (STB),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .en_i       (en_i),
    .sig_i      (sig_i),
    .target_i   (target_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .timeout_o  (timeout_o),
    .err_cnt_o  (err_cnt_o),
    .trans_cnt_o(trans_cnt_o),
    .last_code_o(last_code_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: history of raw samples plus run-level bookkeeping.
  int samp[$];
  int n_samp;
  int m_st, m_cur, m_last, m_err, m_trans, m_tmr, m_target;
  bit m_done, m_pass, m_to;

  task automatic model_reset();
    samp.delete();
    n_samp = 0;
    m_st = M_IDLE; m_cur = 0; m_last = 0; m_err = 0; m_trans = 0;
    m_tmr = 0; m_target = 0; m_done = 0; m_pass = 0; m_to = 0;
  endtask

  task automatic model_step();
    int cand;
    bit stable, acc, en, was_arm;
    int tgt;
    en  = en_i;
    tgt = int'(target_i);
    samp.push_back(int'(sig_i));
    n_samp++;
    if (samp.size() > 32) void'(samp.pop_front());
    // The code seen by the checker lags the pad by three samples; it is accepted
    // once STB consecutive samples agree and differ from the reference.
    cand   = (n_samp >= 4) ? samp[samp.size()-4] : 0;
    stable = (n_samp >= STB + 3);
    if (stable)
      for (int k = 0; k < STB; k++)
        if (samp[samp.size()-4-k] != cand) stable = 0;
    acc     = stable && (cand != m_cur);
    was_arm = (m_st == M_ARM);
    case (m_st)
      M_IDLE: if (en) begin
        m_st = M_ARM; m_err = 0; m_trans = 0; m_to = 0; m_done = 0; m_pass = 0;
        m_tmr = 0; m_target = tgt;
      end
      M_ARM: begin
        if (!en) m_st = M_IDLE;
        else begin
          m_last = cand;
          if (m_target == 0) begin m_st = M_DONE; m_done = 1; m_pass = 1; end
          else m_st = M_RUN;
        end
      end
      M_RUN: begin
        if (!en) m_st = M_IDLE;
        else if (acc) begin
          m_trans = (m_trans + 1) % 65536;
          if (cand != (m_cur + 1) % 8 && m_err < 255) m_err++;
          m_last = cand;
          m_tmr  = 0;
          if (m_trans == m_target) begin m_st = M_DONE; m_done = 1; m_pass = (m_err == 0); end
        end else begin
          m_tmr++;
          if (m_tmr == TMO) begin m_st = M_DONE; m_done = 1; m_to = 1; m_pass = 0; end
        end
      end
      default: if (!en) m_st = M_IDLE;
    endcase
    if (acc || was_arm) m_cur = cand;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  logic [30:0] act_v, exp_v;
  initial begin
    forever begin
      @(negedge clk);
      exp_v = {(m_st == M_ARM || m_st == M_RUN), m_done, m_pass, m_to,
               8'(m_err), 16'(m_trans), 3'(m_last)};
      act_v = {busy_o, done_o, pass_o, timeout_o, err_cnt_o, trans_cnt_o, last_code_o};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual=%h required=%h (busy,done,pass,to,err,trans,last)",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int seq1[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
  int seq2[8] = '{1, 2, 3, 5, 6, 7, 0, 1};
  int t;
  int pick;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; en_i = 1'b0; sig_i = 3'd0; target_i = 16'd0;
    cyc(3);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_trans", trans_cnt_o, 0);
    chk("reset_last", last_code_o, 0);
    rst = 1'b0;
    cyc(10);

    // 1: clean full wrap
    target_i = 16'd8; en_i = 1'b1; cyc(10);
    for (int i = 0; i < 8; i++) begin sig_i = 3'(seq1[i]); cyc(20); end
    chk("t1_trans", trans_cnt_o, 8);
    chk("t1_err", err_cnt_o, 0);
    chk("t1_done", done_o, 1);
    chk("t1_pass", pass_o, 1);
    chk("t1_last", last_code_o, 0);

    // 2: one skipped code
    en_i = 1'b0; cyc(3);
    en_i = 1'b1; cyc(10);
    for (int i = 0; i < 8; i++) begin
      sig_i = 3'(seq2[i]); cyc(20);
      if (i == 3) chk("t2_err_at_skip", err_cnt_o, 1);
    end
    chk("t2_trans", trans_cnt_o, 8);
    chk("t2_err", err_cnt_o, 1);
    chk("t2_pass", pass_o, 0);
    chk("t2_last", last_code_o, 1);

    // 3: glitches of 3 and 4 cycles
    en_i = 1'b0; cyc(3);
    target_i = 16'd20; en_i = 1'b1; cyc(10);
    sig_i = 3'd2; cyc(20);
    chk("t3_first", trans_cnt_o, 1);
    sig_i = 3'd7; cyc(3); sig_i = 3'd2; cyc(20);
    chk("t3_short_glitch", trans_cnt_o, 1);
    sig_i = 3'd7; cyc(4); sig_i = 3'd2; cyc(20);
    chk("t3_long_glitch_trans", trans_cnt_o, 3);
    chk("t3_long_glitch_err", err_cnt_o, 2);

    // 4: timeout after two transitions
    en_i = 1'b0; cyc(3);
    target_i = 16'd5; en_i = 1'b1; cyc(10);
    sig_i = 3'd3; cyc(20);
    sig_i = 3'd4;
    t = 0;
    while (trans_cnt_o != 16'd2 && t < 100) begin cyc(1); t++; end
    chk("t4_two_accepts", trans_cnt_o, 2);
    t = 0;
    while (!done_o && t < 1100) begin cyc(1); t++; end
    chk("t4_timeout_latency", t, 1000);
    chk("t4_timeout", timeout_o, 1);
    chk("t4_pass", pass_o, 0);
    chk("t4_trans", trans_cnt_o, 2);

    // 5: abort, re-enable, zero target
    en_i = 1'b0; cyc(3);
    target_i = 16'd10; en_i = 1'b1; cyc(10);
    for (int i = 5; i < 8; i++) begin sig_i = 3'(i); cyc(20); end
    chk("t5_three", trans_cnt_o, 3);
    en_i = 1'b0; cyc(2);
    chk("t5_abort_busy", busy_o, 0);
    chk("t5_abort_done", done_o, 0);
    chk("t5_abort_hold", trans_cnt_o, 3);
    en_i = 1'b1; cyc(1);
    chk("t5_arm_clear", trans_cnt_o, 0);
    chk("t5_arm_busy", busy_o, 1);
    cyc(5);
    en_i = 1'b0; target_i = 16'd0; cyc(3);
    en_i = 1'b1; cyc(1);
    chk("t5_zero_not_yet", done_o, 0);
    cyc(1);
    chk("t5_zero_done", done_o, 1);
    chk("t5_zero_pass", pass_o, 1);

    // 6: asynchronous reset mid-run
    en_i = 1'b0; cyc(3);
    target_i = 16'd10; en_i = 1'b1; cyc(10);
    sig_i = 3'd0; cyc(20);
    sig_i = 3'd1; cyc(20);
    chk("t6_before", trans_cnt_o, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_trans", trans_cnt_o, 0);
    chk("t6_rst_last", last_code_o, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    chk("t6_arm_after_rst", busy_o, 1);

    // Random runs with glitches, wrong codes and aborts
    for (int r = 0; r < 25; r++) begin
      en_i = 1'b0; cyc(2);
      target_i = 16'($urandom_range(0, 10));
      en_i = 1'b1;
      for (int s = 0; s < 14; s++) begin
        pick = $urandom_range(0, 19);
        if (pick < 13)      sig_i = sig_i + 3'd1;
        else if (pick < 19) sig_i = 3'($urandom);
        else begin en_i = 1'b0; cyc(1); en_i = 1'b1; end
        cyc($urandom_range(1, 24));
      end
      if (r == 5) cyc(TMO + 5);
    end

    en_i = 1'b0; cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_seq_checker.md
Name: sig_seq_checker

Overview:
- Downstream consumer of the user-area signal generator's 3-bit output bus (pads mprj_io[9:7]), instantiated in the user project wrapper.
- Synchronizes and deglitches the 3-bit code, then checks that every accepted change is the expected increment (code+1 mod 8).
- Counts transitions and errors, and reports pass/fail/timeout so the generator can be self-tested in silicon without an external monitor.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles a synchronized code must hold before it is accepted (≥1).
- TIMEOUT_CYCLES, 65535, maximum cycles allowed in RUN without an accepted transition (≥1, ≤2^20-1).
- CNT_W, 16, width of the transition counter and of target_i.

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  asynchronous active-high reset
- en_i  input  1  level enable; high starts and holds a check, low aborts or returns to idle
- sig_i  input  3  generator code, asynchronous to wb_clk_i
- target_i  input  CNT_W  number of transitions to check; sampled on IDLE→ARM
- busy_o  output  1  high in ARM or RUN
- done_o  output  1  check finished; held until the next start
- pass_o  output  1  valid while done_o=1: no errors and no timeout
- timeout_o  output  1  the run ended by timeout
- err_cnt_o  output  8  mismatching transitions, saturates at 255
- trans_cnt_o  output  CNT_W  accepted transitions in this run
- last_code_o  output  3  last accepted code

Behaviour:
- Reset (async, wb_rst_i=1): every output is 0, the FSM is in IDLE, and all internal registers are 0.
- Input path:
  - 2-flop synchronizer s1→s2.
  - Filter: if s2≠cand, then cand←s2 and cnt←0. Otherwise cnt increments, saturating at STABLE_CYCLES-1.
  - Accept fires when cnt==STABLE_CYCLES-1 and cand≠cur. On accept, cur←cand.
  - The filter runs in every state.
  - Latency: with the first sampling edge counted as 1, cur and the counters update on edge STABLE_CYCLES+3.
  - Pulses shorter than STABLE_CYCLES cycles at s2 are ignored.
- FSM states: IDLE, ARM, RUN, DONE.
  - IDLE: busy=0 and the results are held. On en_i=1 → ARM, which clears err_cnt, trans_cnt, timeout, done, pass and the idle timer, and latches target_i.
  - ARM (1 cycle): cur←cand and last_code_o←cand, which sets the reference code without counting a transition. If the latched target==0 → DONE with pass=1. Otherwise → RUN.
  - RUN, on accept:
    - trans_cnt increments.
    - If new==cur+1 mod 8 (7→0 is valid), the transition is good. Otherwise err_cnt increments, saturating at 255.
    - last_code_o←new and the idle timer←0.
    - When trans_cnt reaches the target on this accept → DONE with pass=(err_cnt==0 after this update).
  - RUN, without accept: the idle timer increments. When it reaches TIMEOUT_CYCLES → DONE with timeout=1 and pass=0.
  - DONE: done=1 and busy=0. Accepts are no longer counted. Stays in DONE while en_i=1; en_i=0 → IDLE.
- en_i=0 in ARM or RUN: abort to IDLE. done, pass and timeout stay 0 and counters hold their values.
- Simultaneous events:
  - An accept and a timeout in the same cycle: the accept wins and the timer is cleared.
  - en_i=0 in the same cycle: abort wins.
- done, pass and timeout are registered. They change on the same edge that enters DONE.
- wb_rst_i asserted mid-run: immediate clear to reset values. There is no partial-result retention.

Test Plan (STABLE_CYCLES=4, TIMEOUT_CYCLES=1000):
1. sig_i=000 settled, target=8, en=1, then step sig_i 001..111,000 every 20 cycles → trans_cnt=8, err_cnt=0, done=1, pass=1, last_code=000.
2. Same as 1 but 011→101 (skips 100) → err_cnt=1 at that step; subsequent 101→110 is good; done with pass=0, trans_cnt=8.
3. Glitch sig_i to 111 for 3 cycles during RUN → no accept, trans_cnt unchanged. Glitch of 4 cycles → accepted as a transition, error counted, then the return to the old code is counted as a second transition.
4. target=5, only 2 transitions, then sig_i held → timeout_o=1, pass=0, done=1 exactly 1000 cycles after the last accept; trans_cnt=2.
5. en=0 mid-run after 3 transitions → IDLE, busy=0, done=0, trans_cnt holds 3. Re-enable → counters clear to 0 in ARM. Also target=0 → done=1, pass=1 two cycles after en rises.
6. Assert wb_rst_i asynchronously between clock edges in RUN → all outputs 0 immediately. Release reset with en=1 → ARM on the next edge.
